// File: rtl/stream_gen_pkg.sv
// stream_gen_pkg: shared state enum, LFSR tap masks (widths 3..16) and pattern step function for stream_gen.
package stream_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;
  localparam int MAX_W = 16;
  function automatic logic [MAX_W-1:0] lfsr_taps(input int w);
    case (w)
      3: return 16'h0006;
      4: return 16'h000C;
      5: return 16'h0014;
      6: return 16'h0030;
      7: return 16'h0060;
      8: return 16'h00B8;
      9: return 16'h0110;
      10: return 16'h0240;
      11: return 16'h0500;
      12: return 16'h0829;
      13: return 16'h100D;
      14: return 16'h2015;
      15: return 16'h6000;
      16: return 16'hD008;
      default: return '0;
    endcase
  endfunction
  function automatic logic [MAX_W-1:0] next_pattern(input logic [MAX_W-1:0] cur, input int w, input logic lfsr);
    logic [MAX_W-1:0] m;
    m = MAX_W'((32'd1 << w) - 32'd1);
    return lfsr ? ({cur[MAX_W-2:0], ^(cur & lfsr_taps(w))} & m) : ((cur + 1'b1) & m);
  endfunction
endpackage

// File: rtl/stream_gen_if.sv
// stream_gen_if: valid/ready stream bus; master drives down_data/down_valid, slave drives down_ready.
interface stream_gen_if #(parameter int D_WIDTH = 6);
  logic [D_WIDTH-1:0] down_data;
  logic down_valid;
  logic down_ready;
  modport master(output down_data, down_valid, input down_ready);
  modport slave(input down_data, down_valid, output down_ready);
endinterface

// File: rtl/stream_gen_pattern.sv
// stream_gen_pattern: pattern word register (ports: clk, rst, load_i, advance_i, seed_i, word_o); STREAM_GEN_LFSR_EN selects LFSR instead of counter.
module stream_gen_pattern import stream_gen_pkg::*; #(
  parameter int D_WIDTH = 6
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               advance_i,
  input  logic [D_WIDTH-1:0] seed_i,
  output logic [D_WIDTH-1:0] word_o
);
  logic [D_WIDTH-1:0] word_q, word_d, seed_eff;
`ifdef STREAM_GEN_LFSR_EN
  localparam logic LFSR = 1'b1;
  // all-zero is the LFSR lock-up state, so a zero seed starts at all-ones
  assign seed_eff = (seed_i == '0) ? '1 : seed_i;
`else
  localparam logic LFSR = 1'b0;
  assign seed_eff = seed_i;
`endif
  always_comb word_d = load_i ? seed_eff : advance_i ? D_WIDTH'(next_pattern(MAX_W'(word_q), D_WIDTH, LFSR)) : word_q;
  always_ff @(posedge clk) word_q <= rst ? '0 : word_d;
  assign word_o = word_q;
endmodule

// File: rtl/stream_gen.sv
// stream_gen: burst stream transmitter (ports: clk, rst, start, burst_len, gap_cycles, seed, down bus, busy, done, sent_count); STREAM_GEN_LFSR_EN enables LFSR pattern.
module stream_gen import stream_gen_pkg::*; #(
  parameter int D_WIDTH   = 6,
  parameter int LEN_WIDTH = 8,
  parameter int GAP_WIDTH = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  input  logic [GAP_WIDTH-1:0] gap_cycles,
  input  logic [D_WIDTH-1:0]   seed,
  stream_gen_if.master         down,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] sent_count
);
  state_e state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, sent_q, sent_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d, cnt_q, cnt_d;
  logic load, hs, last;
  assign load = state_q == IDLE && start;
  assign hs = down.down_valid && down.down_ready;
  assign last = sent_q + 1'b1 == len_q;
  always_comb begin
    state_d = state_q;
    len_d = load ? burst_len : len_q;
    gap_d = load ? gap_cycles : gap_q;
    sent_d = load ? '0 : (hs && sent_q != len_q) ? sent_q + 1'b1 : sent_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = !start ? IDLE : (burst_len != '0) ? SEND : DONE;
      SEND: if (hs) begin
        state_d = last ? DONE : (gap_q != '0) ? GAP : SEND;
        cnt_d = gap_q;
      end
      // cnt_q runs G..1, giving exactly G idle cycles
      GAP: begin
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == GAP_WIDTH'(1)) ? SEND : GAP;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      gap_q <= '0;
      sent_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      gap_q <= gap_d;
      sent_q <= sent_d;
      cnt_q <= cnt_d;
    end
  end
  stream_gen_pattern #(.D_WIDTH(D_WIDTH)) u_pattern (
    .clk(clk), .rst(rst), .load_i(load), .advance_i(hs), .seed_i(seed), .word_o(down.down_data)
  );
  assign down.down_valid = state_q == SEND;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sent_count = sent_q;
endmodule
